// File: rtl/alu_mc_pkg.sv
// Shared op-codes, FSM state and status-flag types for the multi-cycle ALU.
package alu_mc_pkg;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_MUL  = 4'b0011;
    localparam logic [3:0] ALU_SLL  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_PASS = 4'b1000;
    localparam logic [3:0] ALU_XOR  = 4'b1001;
    localparam logic [3:0] ALU_NOR  = 4'b1010;
    localparam logic [3:0] ALU_SLTU = 4'b1100;
    localparam logic [3:0] ALU_SRA  = 4'b1101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic n;
        logic z;
        logic v;
        logic c;
    } flags_t;

endpackage

// File: rtl/alu_mul_seq.sv
// Iterative right-shift/add unsigned multiplier: one partial product per cycle,
// done_o pulses with the full product on the WIDTH-th step.
module alu_mul_seq #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    output logic               done_o,
    output logic [2*WIDTH-1:0] product_o
);

    localparam int CW = $clog2(WIDTH);

    logic             busy_q, busy_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH:0]   sum;

    // product_o is the value after the current step, so the caller can load it on the done edge
    always_comb begin
        sum       = {1'b0, hi_q} + (lo_q[0] ? {1'b0, a_q} : '0);
        product_o = {sum[WIDTH:1], sum[0], lo_q[WIDTH-1:1]};
        done_o    = busy_q && (count_q == CW'(WIDTH - 1));
        busy_d    = busy_q;
        count_d   = count_q;
        a_d       = a_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        if (start_i) begin
            busy_d  = 1'b1;
            count_d = '0;
            a_d     = a_i;
            hi_d    = '0;
            lo_d    = b_i;
        end else if (busy_q) begin
            hi_d    = product_o[2*WIDTH-1:WIDTH];
            lo_d    = product_o[WIDTH-1:0];
            count_d = count_q + 1'b1;
            if (done_o) begin
                busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q  <= 1'b0;
            count_q <= '0;
            a_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            busy_q  <= busy_d;
            count_q <= count_d;
            a_q     <= a_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU with valid/ready handshake and sticky N/Z/V/C flags.
// Define ALU_MUL_EN to build the iterative MUL; otherwise code 0011 is illegal.
module alu_mc
    import alu_mc_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_set_flags,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_zero,
    output logic             out_illegal,
    output logic             status_n,
    output logic             status_z,
    output logic             status_v,
    output logic             status_c
);

    localparam int SHW = $clog2(WIDTH);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             illegal_q, illegal_d;
    flags_t           flags_q, flags_d;

    logic [SHW-1:0]   shAmt;
    logic [WIDTH:0]   addSum, subSum, sllExt, srlExt, sraExt;
    logic [WIDTH-1:0] aluRes;
    logic             aluV, aluC, aluIllegal;

`ifdef ALU_MUL_EN
    logic               setFlags_q, setFlags_d;
    logic               mulStart, mulDone;
    logic [2*WIDTH-1:0] mulProduct;

    alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
        .clk       (clk),
        .rst       (rst),
        .start_i   (mulStart),
        .a_i       (in_a),
        .b_i       (in_b),
        .done_o    (mulDone),
        .product_o (mulProduct)
    );
`endif

    // Shifts carry one extra bit so the last bit shifted out lands in the spare position
    always_comb begin
        shAmt      = in_b[SHW-1:0];
        addSum     = {1'b0, in_a} + {1'b0, in_b};
        subSum     = {1'b0, in_a} + {1'b0, ~in_b} + (WIDTH+1)'(1);
        sllExt     = {1'b0, in_a} << shAmt;
        srlExt     = {in_a, 1'b0} >> shAmt;
        sraExt     = $signed({in_a, 1'b0}) >>> shAmt;
        aluRes     = '0;
        aluV       = 1'b0;
        aluC       = 1'b0;
        aluIllegal = 1'b0;
        case (in_op)
            ALU_ADD: begin
                aluRes = addSum[WIDTH-1:0];
                aluC   = addSum[WIDTH];
                aluV   = (in_a[WIDTH-1] == in_b[WIDTH-1]) && (addSum[WIDTH-1] != in_a[WIDTH-1]);
            end
            ALU_SUB: begin
                aluRes = subSum[WIDTH-1:0];
                aluC   = subSum[WIDTH];
                aluV   = (in_a[WIDTH-1] != in_b[WIDTH-1]) && (subSum[WIDTH-1] != in_a[WIDTH-1]);
            end
            ALU_SLT:  aluRes = {{(WIDTH-1){1'b0}}, ($signed(in_a) < $signed(in_b))};
            ALU_SLTU: aluRes = {{(WIDTH-1){1'b0}}, (in_a < in_b)};
            ALU_AND:  aluRes = in_a & in_b;
            ALU_OR:   aluRes = in_a | in_b;
            ALU_NOR:  aluRes = ~(in_a | in_b);
            ALU_XOR:  aluRes = in_a ^ in_b;
            ALU_PASS: aluRes = in_a;
            ALU_SLL: begin
                aluRes = sllExt[WIDTH-1:0];
                aluC   = sllExt[WIDTH];
            end
            ALU_SRL: begin
                aluRes = srlExt[WIDTH:1];
                aluC   = srlExt[0];
            end
            ALU_SRA: begin
                aluRes = sraExt[WIDTH:1];
                aluC   = sraExt[0];
            end
`ifdef ALU_MUL_EN
            ALU_MUL:  aluRes = '0;
`endif
            default:  aluIllegal = 1'b1;
        endcase
    end

    // Next-state logic; result, zero, illegal and flags all load on the edge that enters DONE
    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        zero_d    = zero_q;
        illegal_d = illegal_q;
        flags_d   = flags_q;
`ifdef ALU_MUL_EN
        setFlags_d = setFlags_q;
        mulStart   = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
`ifdef ALU_MUL_EN
                    if (in_op == ALU_MUL) begin
                        mulStart   = 1'b1;
                        setFlags_d = in_set_flags;
                        state_d    = BUSY;
                    end else
`endif
                    begin
                        result_d  = aluRes;
                        zero_d    = (aluRes == '0);
                        illegal_d = aluIllegal;
                        if (in_set_flags && !aluIllegal) begin
                            flags_d = '{n: aluRes[WIDTH-1], z: (aluRes == '0), v: aluV, c: aluC};
                        end
                        state_d = DONE;
                    end
                end
            end
            BUSY: begin
`ifdef ALU_MUL_EN
                if (mulDone) begin
                    result_d  = mulProduct[WIDTH-1:0];
                    zero_d    = (mulProduct[WIDTH-1:0] == '0);
                    illegal_d = 1'b0;
                    if (setFlags_q) begin
                        flags_d = '{n: mulProduct[WIDTH-1], z: (mulProduct[WIDTH-1:0] == '0),
                                    v: (mulProduct[2*WIDTH-1:WIDTH] != '0), c: 1'b0};
                    end
                    state_d = DONE;
                end
`else
                state_d = IDLE;
`endif
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            result_q  <= '0;
            zero_q    <= 1'b1;
            illegal_q <= 1'b0;
            flags_q   <= '0;
`ifdef ALU_MUL_EN
            setFlags_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            result_q  <= result_d;
            zero_q    <= zero_d;
            illegal_q <= illegal_d;
            flags_q   <= flags_d;
`ifdef ALU_MUL_EN
            setFlags_q <= setFlags_d;
`endif
        end
    end

    assign in_ready    = (state_q == IDLE);
    assign out_valid   = (state_q == DONE);
    assign out_result  = result_q;
    assign out_zero    = zero_q;
    assign out_illegal = illegal_q;
    assign status_n    = flags_q.n;
    assign status_z    = flags_q.z;
    assign status_v    = flags_q.v;
    assign status_c    = flags_q.c;

endmodule
